memc_deskew: RTL and testbench
==============================

MEMC_DESKEW -- requirements
Module: memc_deskew

Interface
REQ-001 Parameter BITS_C, default 16, SHALL set the signed width of one result element.
REQ-002 Parameter DIM, default 8, SHALL set the matrix dimension (rows = columns = DIM).
REQ-003 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1, SHALL be the synchronous, active-high reset.
REQ-005 Port start, input, 1, SHALL be a one-cycle pulse that begins a new collection.
REQ-006 Port en, input, 1, SHALL be the systolic-array step strobe; one capture step per cycle with en high.
REQ-007 Port Cin, input, signed [BITS_C-1:0] x DIM, SHALL carry the skewed column outputs of the array; column j lags column 0 by j steps.
REQ-008 Port Crow, input, $clog2(DIM), SHALL select the row presented on Cout.
REQ-009 Port Cout, output, signed [BITS_C-1:0] x DIM, SHALL present buffered row Crow, column-aligned.
REQ-010 Port busy, output, 1, SHALL be high while in COLLECT.
REQ-011 Port done, output, 1, SHALL be high while in DONE.

Function
REQ-012 Storage SHALL be a DIM x DIM array buf[r][c] of signed BITS_C registers.
REQ-013 A step counter t SHALL count 0 .. 2*DIM-2.
REQ-014 The FSM SHALL have exactly three states: IDLE, COLLECT, DONE.
REQ-015 IDLE: start -> COLLECT with t=0 and all buf cleared to 0; otherwise hold.
REQ-016 COLLECT, en high: for each column j with 0 <= t-j < DIM, buf[t-j][j] SHALL capture Cin[j]; all other entries SHALL hold.
REQ-017 COLLECT, en high, t < 2*DIM-2: t SHALL increment by 1.
REQ-018 COLLECT, en high, t == 2*DIM-2: the capture SHALL occur and the next state SHALL be DONE; t SHALL return to 0.
REQ-019 COLLECT, en low: t, buf and state SHALL hold (stall).
REQ-020 DONE: buf SHALL hold; state SHALL remain DONE until start.
REQ-021 start in any state SHALL take priority over en: no capture that cycle; buf cleared, t=0, next state COLLECT.
REQ-022 Total latency from the cycle after start to done high SHALL be exactly 2*DIM-1 en-high cycles.
REQ-023 Cout SHALL be combinational from buf[Crow] (zero-cycle read latency), valid in every state; in COLLECT, not-yet-captured entries read 0.
REQ-024 If Crow >= DIM (non-power-of-2 DIM), Cout SHALL be all zeros.
REQ-025 Cin values SHALL be stored unmodified (no saturation, rounding or sign change).

Reset
REQ-026 rst high SHALL force state IDLE, t=0, all buf entries 0, busy=0, done=0 on the next rising clk edge, overriding start and en.
REQ-027 rst asserted mid-COLLECT SHALL abandon the collection; a later start SHALL run a full 2*DIM-1 step collection.
REQ-028 After reset with Crow=0, Cout SHALL read all zeros.

Verification
REQ-029 DIM=4: rst, start, then 7 en cycles driving Cin[j] = 10*(t-j)+j where valid, else 0x7FFF -> done after the 7th en; Crow=r reads {10r, 10r+1, 10r+2, 10r+3}; no 0x7FFF stored.
REQ-030 DIM=4 stall: same stimulus with en low for 3 cycles after t=2 -> busy stays 1, buf unchanged during stall, final contents identical to REQ-029, done after 7 en-high cycles.
REQ-031 Restart: start pulsed at t=4 of a collection -> buf reads all zeros next cycle, busy=1, t=0; full new collection completes correctly.
REQ-032 start and en high in same IDLE cycle with Cin all 5 -> no capture; Crow=0 reads zeros; the next en captures buf[0][0].
REQ-033 Reset mid-op: rst at t=3 -> next cycle busy=0, done=0, Cout all 0 for every Crow.
REQ-034 Sign: Cin[0] = -32768 at t=0 -> Crow=0 yields Cout[0] = -32768 after done.

Source files
------------

// File: rtl/memc_deskew.sv
// Deskew buffer for a DIM x DIM systolic array: captures the diagonally skewed
// column outputs into a row-aligned register matrix and serves one row at a time.
module memc_deskew #(
    parameter int BITS_C = 16,
    parameter int DIM    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     en,
    input  logic signed [BITS_C-1:0] Cin  [DIM],
    input  logic [$clog2(DIM)-1:0]   Crow,
    output logic signed [BITS_C-1:0] Cout [DIM],
    output logic                     busy,
    output logic                     done
);

    localparam int TW = $clog2(2*DIM-1);
    localparam logic [TW-1:0] T_LAST = TW'(2*DIM-2);

    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

    state_t state_q, state_d;
    logic [TW-1:0] t_q;
    logic signed [BITS_C-1:0] cbuf [DIM][DIM];

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE:    ;
            COLLECT: begin
                busy = 1'b1;
                if (en && t_q == T_LAST) state_d = DONE;
            end
            DONE:    done = 1'b1;
            default: state_d = IDLE;
        endcase
        if (start) state_d = COLLECT;
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Entry (r,c) sits on anti-diagonal r+c, so it is written on step t == r+c.
    always_ff @(posedge clk) begin
        if (rst || start) begin
            t_q <= '0;
            for (int unsigned r = 0; r < DIM; r++)
                for (int unsigned c = 0; c < DIM; c++)
                    cbuf[r][c] <= '0;
        end else if (state_q == COLLECT && en) begin
            for (int unsigned r = 0; r < DIM; r++)
                for (int unsigned c = 0; c < DIM; c++)
                    if (32'(t_q) == r + c) cbuf[r][c] <= Cin[c];
            t_q <= (t_q == T_LAST) ? '0 : t_q + 1'b1;
        end
    end

    always_comb begin
        for (int unsigned c = 0; c < DIM; c++) begin
            Cout[c] = '0;
            if (32'(Crow) < 32'(DIM)) Cout[c] = cbuf[Crow][c];
        end
    end

endmodule

// File: tb/tb_memc_deskew.sv
// Directed bench for memc_deskew at DIM=4, BITS_C=16.
module tb_memc_deskew;

    logic               clk = 1'b0;
    logic               rst, start, en;
    logic signed [15:0] cin  [4];
    logic        [1:0]  crow;
    logic signed [15:0] cout [4];
    logic               busy, done;
    int                 n_cmp = 0;
    int                 n_err = 0;

    memc_deskew #(.BITS_C(16), .DIM(4)) dut (
        .clk(clk), .rst(rst), .start(start), .en(en),
        .Cin(cin), .Crow(crow), .Cout(cout), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd_row(input int r, output logic [63:0] v);
        crow = 2'(r);
        #1;
        v = {cout[3], cout[2], cout[1], cout[0]};
    endtask

    function automatic logic [63:0] erow(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    function automatic logic [63:0] prow(input int r);
        return erow(10*r, 10*r+1, 10*r+2, 10*r+3);
    endfunction

    // Skewed array output at step t: column j carries element (t-j, j), else filler.
    task automatic drive_cin(input int t);
        for (int j = 0; j < 4; j++)
            cin[j] = (t >= j && t - j < 4) ? 16'(10*(t-j)+j) : 16'sh7FFF;
    endtask

    task automatic en_steps(input int t0, input int t1);
        for (int t = t0; t <= t1; t++) begin
            en = 1'b1;
            drive_cin(t);
            tick();
        end
        en = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic check_all_rows(input string tag);
        logic [63:0] v;
        for (int r = 0; r < 4; r++) begin
            rd_row(r, v);
            check(tag, v, prow(r));
        end
    endtask

    initial begin
        logic [63:0] v;
        rst = 1'b1; start = 1'b0; en = 1'b0; crow = '0;
        for (int j = 0; j < 4; j++) cin[j] = '0;

        // Reset state
        tick();
        rst = 1'b0;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        rd_row(0, v);
        check("rst_row0", v, 64'd0);

        // en without start stays idle
        en = 1'b1; tick(); en = 1'b0;
        check("idle_en_busy", 64'(busy), 64'd0);

        // Basic collection
        pulse_start();
        check("start_busy", 64'(busy), 64'd1);
        check("start_done", 64'(done), 64'd0);
        en_steps(0, 2);
        rd_row(0, v);
        check("partial_row0", v, erow(0, 1, 2, 0));
        en_steps(3, 5);
        check("six_en_done", 64'(done), 64'd0);
        en_steps(6, 6);
        check("basic_done", 64'(done), 64'd1);
        check("basic_busy", 64'(busy), 64'd0);
        check_all_rows("basic_row");

        // Stall after t=2, started from DONE
        pulse_start();
        en_steps(0, 2);
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 4; j++) cin[j] = 16'sh1234;
            tick();
            check("stall_busy", 64'(busy), 64'd1);
        end
        rd_row(0, v);
        check("stall_row0", v, erow(0, 1, 2, 0));
        rd_row(1, v);
        check("stall_row1", v, erow(10, 11, 0, 0));
        en_steps(3, 5);
        check("stall_not_done", 64'(done), 64'd0);
        en_steps(6, 6);
        check("stall_done", 64'(done), 64'd1);
        check_all_rows("stall_row");

        // Restart at t=4, start wins over en
        pulse_start();
        en_steps(0, 3);
        start = 1'b1; en = 1'b1; drive_cin(4);
        tick();
        start = 1'b0; en = 1'b0;
        check("restart_busy", 64'(busy), 64'd1);
        rd_row(0, v);
        check("restart_row0", v, 64'd0);
        rd_row(1, v);
        check("restart_row1", v, 64'd0);
        en_steps(0, 6);
        check("restart_done", 64'(done), 64'd1);
        check_all_rows("restart_row");

        // Done holds under further en
        en_steps(0, 1);
        check("done_hold", 64'(done), 64'd1);
        rd_row(3, v);
        check("done_hold_row3", v, prow(3));

        // start and en together in IDLE
        rst = 1'b1; tick(); rst = 1'b0;
        start = 1'b1; en = 1'b1;
        for (int j = 0; j < 4; j++) cin[j] = 16'sd5;
        tick();
        start = 1'b0;
        rd_row(0, v);
        check("se_no_capture", v, 64'd0);
        check("se_busy", 64'(busy), 64'd1);
        tick();
        en = 1'b0;
        rd_row(0, v);
        check("se_first_capture", v, erow(5, 0, 0, 0));
        rd_row(1, v);
        check("se_row1", v, 64'd0);

        // Reset mid-collection at t=3
        pulse_start();
        en_steps(0, 2);
        rst = 1'b1; en = 1'b1; drive_cin(3);
        tick();
        rst = 1'b0; en = 1'b0;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        for (int r = 0; r < 4; r++) begin
            rd_row(r, v);
            check("midrst_row", v, 64'd0);
        end
        pulse_start();
        en_steps(0, 5);
        check("post_rst_not_done", 64'(done), 64'd0);
        en_steps(6, 6);
        check("post_rst_done", 64'(done), 64'd1);
        check_all_rows("post_rst_row");

        // Most negative value stored unmodified
        pulse_start();
        en = 1'b1; drive_cin(0); cin[0] = -16'sd32768;
        tick();
        en_steps(1, 6);
        check("sign_done", 64'(done), 64'd1);
        rd_row(0, v);
        check("sign_row0", v, {16'd3, 16'd2, 16'd1, 16'h8000});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
